cordic_range_reduce: RTL and testbench

//  Upstream feeder for the pipelined CORDIC rotator (cordic_updated).
//  - Accepts any signed Q16.16 angle theta in radians.
//  - Reduces it to [-pi/2, +pi/2] and presents x0/y0/z0 in the form the CORDIC expects:
//    x0 = 1/K pre-scale, y0 = 0, z0 = reduced angle.
//  - Multi-cycle FSM with valid/ready handshakes on both sides.
//  - out_neg marks a pi fold; the downstream sign-fix stage negates X and Y when it is set.

---
 rtl/cordic_range_reduce_if.sv | 25 ++
 rtl/cordic_range_reduce.sv | 135 +++++++++++++
 tb/tb_cordic_range_reduce.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_range_reduce_if.sv
// Handshake bundle between an angle source, the range reducer and the CORDIC front end.
// The theta side and the x0/y0/z0 side each use their own valid/ready pair.
interface cordic_range_reduce_if #(
  parameter int unsigned W = 32
);
  logic         [W-1:0] theta;
  logic                 in_valid;
  logic                 in_ready;
  logic signed  [W-1:0] x0;
  logic signed  [W-1:0] y0;
  logic signed  [W-1:0] z0;
  logic                 out_neg;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output theta, in_valid, out_ready,
    input  in_ready, x0, y0, z0, out_neg, out_valid
  );

  modport slave (
    input  theta, in_valid, out_ready,
    output in_ready, x0, y0, z0, out_neg, out_valid
  );
endinterface

// File: rtl/cordic_range_reduce.sv
// Reduces a signed Q16.16 angle to [-pi/2, +pi/2] for the CORDIC rotator; out_neg flags a pi
// fold so the downstream stage negates X and Y. Fixed latency regardless of theta.
module cordic_range_reduce #(
  parameter int unsigned W        = 32,
  parameter int          TWO_PI   = 411775,
  parameter int          PI       = 205887,
  parameter int          HALF_PI  = 102944,
  parameter int          KINV     = 39797,
  parameter int unsigned COARSE_N = 13
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cordic_range_reduce_if.slave   bus
);

  localparam int unsigned KW = (COARSE_N > 1) ? $clog2(COARSE_N) : 1;
  localparam logic signed [W+1:0] TwoPiX  = (W+2)'(TWO_PI);
  localparam logic signed [W+1:0] PiX     = (W+2)'(PI);
  localparam logic signed [W+1:0] HalfPiX = (W+2)'(HALF_PI);

  typedef enum logic [2:0] {StIdle, StCoarse, StWrap, StFold, StDone} state_e;

  state_e               state_q, state_d;
  logic signed [W+1:0]  acc_q, acc_d;
  logic        [KW-1:0] k_q, k_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_neg_q, out_neg_d;
  logic signed [W-1:0]  x0_q, x0_d;
  logic signed [W-1:0]  y0_q, y0_d;
  logic signed [W-1:0]  z0_q, z0_d;
  logic signed [W+1:0]  step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_neg_q   <= 1'b0;
      x0_q        <= '0;
      y0_q        <= '0;
      z0_q        <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_neg_q   <= out_neg_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      z0_q        <= z0_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    k_d         = k_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_neg_d   = out_neg_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    z0_d        = z0_q;
    step        = TwoPiX <<< k_q;

    unique case (state_q)
      StIdle: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          acc_d      = {{2{bus.theta[W-1]}}, bus.theta};
          k_d        = KW'(COARSE_N - 1);
          in_ready_d = 1'b0;
          state_d    = StCoarse;
        end
      end
      // Binary-weighted subtraction of 2pi multiples, largest first.
      StCoarse: begin
        if (acc_q >= step) begin
          acc_d = acc_q - step;
        end else if (acc_q <= -step) begin
          acc_d = acc_q + step;
        end
        if (k_q == '0) begin
          state_d = StWrap;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      StWrap: begin
        if (acc_q > PiX) begin
          acc_d = acc_q - TwoPiX;
        end else if (acc_q < -PiX) begin
          acc_d = acc_q + TwoPiX;
        end
        state_d = StFold;
      end
      StFold: begin
        if (acc_q > HalfPiX) begin
          z0_d      = W'(acc_q - PiX);
          out_neg_d = 1'b1;
        end else if (acc_q < -HalfPiX) begin
          z0_d      = W'(acc_q + PiX);
          out_neg_d = 1'b1;
        end else begin
          z0_d      = W'(acc_q);
          out_neg_d = 1'b0;
        end
        x0_d        = W'(KINV);
        y0_d        = '0;
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_neg   = out_neg_q;
  assign bus.x0        = x0_q;
  assign bus.y0        = y0_q;
  assign bus.z0        = z0_q;

endmodule

// File: tb/tb_cordic_range_reduce.sv
// Directed-vector bench for cordic_range_reduce: reduction results, latency, stall, reset and
// back-to-back throughput against hand-computed values.
module tb_cordic_range_reduce;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  cordic_range_reduce_if #(.W(32)) bus ();

  cordic_range_reduce dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s in_ready timeout: got %b want 1", nm, bus.in_ready);
    end
  endtask

  // Accept theta, measure accept-to-valid latency, check results, optionally complete handshake.
  task automatic run_angle(input logic [31:0] th, input logic signed [31:0] ez, input logic en,
                           input string nm, input bit handshake);
    int n;
    wait_ready(nm);
    bus.theta    = th;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (bus.out_valid !== 1'b1 && n < 40);
    vectors++;
    if (n !== 15) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want 15", nm, n);
    end
    vectors++;
    if (bus.z0 !== ez || bus.out_neg !== en) begin
      miscompares++;
      $display("FAIL %s result: got z0=%0d neg=%b want z0=%0d neg=%b",
               nm, bus.z0, bus.out_neg, ez, en);
    end
    vectors++;
    if (bus.x0 !== 32'sd39797 || bus.y0 !== 32'sd0) begin
      miscompares++;
      $display("FAIL %s x0/y0: got %0d/%0d want 39797/0", nm, bus.x0, bus.y0);
    end
    if (handshake) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.z0 !== ez) begin
        miscompares++;
        $display("FAIL %s post-handshake: got valid=%b z0=%0d want valid=0 z0=%0d",
                 nm, bus.out_valid, bus.z0, ez);
      end
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.theta     = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.z0 !== 0 || bus.x0 !== 0 ||
        bus.y0 !== 0 || bus.out_neg !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: got rdy=%b vld=%b x0=%0d y0=%0d z0=%0d neg=%b want all 0",
               bus.in_ready, bus.out_valid, bus.x0, bus.y0, bus.z0, bus.out_neg);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_before_edge: got %b want 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_edge: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_reduction();
    run_angle(32'd102943,    32'sd102943, 1'b0, "below_half_pi", 1'b1);
    run_angle(32'd477311,    32'sd65536,  1'b0, "two_pi_plus_one", 1'b1);
    run_angle(32'd205887,    32'sd0,      1'b1, "plus_pi", 1'b1);
    run_angle(-32'sd205887,  32'sd0,      1'b1, "minus_pi", 1'b1);
    run_angle(-32'sd154415,  32'sd51472,  1'b1, "neg_fold", 1'b1);
    run_angle(32'd102944,    32'sd102944, 1'b0, "half_pi_edge", 1'b1);
    run_angle(32'h7FFFFFFF,  32'sd77022,  1'b0, "max_pos", 1'b1);
    run_angle(32'h80000000, -32'sd77023,  1'b0, "max_neg", 1'b1);
  endtask

  task automatic test_stall();
    run_angle(-32'sd154415, 32'sd51472, 1'b1, "stall", 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.theta    = 32'd0;
      bus.in_valid = 1'b1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.z0 !== 32'sd51472 ||
          bus.out_neg !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got vld=%b rdy=%b z0=%0d neg=%b want 1 0 51472 1",
                 i, bus.out_valid, bus.in_ready, bus.z0, bus.out_neg);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.z0 !== 32'sd51472 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: got vld=%b z0=%0d rdy=%b want 0 51472 1",
               bus.out_valid, bus.z0, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    wait_ready("reset_mid");
    bus.theta    = 32'd477311;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.z0 !== 0) begin
      miscompares++;
      $display("FAIL reset_mid: got vld=%b rdy=%b z0=%0d want 0 0 0",
               bus.out_valid, bus.in_ready, bus.z0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_ready: got %b want 1", bus.in_ready);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_discard: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    bus.out_ready = 1'b1;
    wait_ready("b2b");
    bus.theta    = 32'd205887;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.theta = -32'sd154415;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (bus.in_ready !== 1'b1 && gap < 40);
    vectors++;
    if (gap !== 17) begin
      miscompares++;
      $display("FAIL b2b_gap: got %0d want 17", gap);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    gap = 0;
    do begin
      @(posedge clk);
      #1 gap++;
    end while (bus.out_valid !== 1'b1 && gap < 40);
    vectors++;
    if (gap !== 15 || bus.z0 !== 32'sd51472 || bus.out_neg !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d z0=%0d neg=%b want 15 51472 1",
               gap, bus.z0, bus.out_neg);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_reduction();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    run_angle(32'd477311, 32'sd65536, 1'b0, "after_all", 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
